dmem_responder: RTL and testbench

- Data-memory responder: the target side of the CPU load/store interface.
- Accepts one word request at a time over a valid/ready handshake and performs it on an internal word-addressed array.
- Returns read data, or a write acknowledge, after a configurable latency; the response is held until the initiator takes it.
- Replaces the zero-latency combinational RAM so CPU stall/handshake logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: target side of the CPU load/store interface.
// Accepts one word request at a time, performs it on an internal word array and
// returns read data or a write acknowledge LATENCY cycles after acceptance. The
// response is held until the initiator takes it.
// Optional build macro: DMEM_RESPONDER_STATS_EN adds read/write/error counters.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request, req_ready=1
// WAIT   | request accepted, latency counter running down to zero
// RESP   | response registered and presented until resp_ready

module dmem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errs
`endif
);

    localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W  = 30'(MEM_DEPTH);

    logic [1:0]    state;
    logic [3:0]    lat_cnt;
    logic          lat_we;
    logic          lat_err;
    logic [AW-1:0] lat_idx;
    logic [31:0]   mem [MEM_DEPTH];

    logic          accept;
    logic          req_err_now;
    logic [AW-1:0] req_idx;

    // Request qualification and error classification at the accept edge
    always_comb begin
        req_ready   = (state == S_IDLE);
        accept      = req_valid && req_ready;
        req_err_now = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);
        req_idx     = req_addr[AW+1:2];
    end

    // Array write, committed at accept; erroring requests never touch the array
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err_now) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM, latency down-counter and registered response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lat_cnt    <= 4'd0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we  <= req_we;
                        lat_err <= req_err_now;
                        lat_idx <= req_idx;
                        lat_cnt <= CNT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        // Read data is sampled here, so it sees every earlier write
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        resp_rdata <= (lat_we || lat_err) ? 32'd0 : mem[lat_idx];
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_RESPONDER_STATS_EN
    // Transaction counters; an erroring request counts as an error and as its kind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_errs   <= 32'd0;
        end else if (accept) begin
            if (req_we) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (req_err_now) begin
                stat_errs <= stat_errs + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset and
// backpressure sequences, then randomized traffic against an array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_RESPONDER_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_errs;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef DMEM_RESPONDER_STATS_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
        .stat_errs  (stat_errs)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int hold,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.hold = hold;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Reference: a plain word array updated by byte lanes; errors leave it untouched
    task automatic model_apply(input vec_t v, output logic [31:0] rd, output logic e);
        int idx;
        e  = (v.addr[1:0] != 2'b00) || (v.addr[31:2] >= DEPTH);
        rd = 32'd0;
        if (!e) begin
            idx = int'(v.addr[31:2]);
            if (v.we) begin
                for (int i = 0; i < 4; i++)
                    if (v.be[i]) ref_mem[idx][8*i +: 8] = v.wdata[8*i +: 8];
                if (v.be == 4'hF) known[idx] = 1'b1;
            end else begin
                rd = ref_mem[idx];
            end
        end
    endtask

    task automatic scramble_req();
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // One full transaction: offer, measure latency, optional backpressure, retire
    task automatic txn(input vec_t v);
        int  lat;
        bit  seen;
        @(negedge clk);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_be     = v.be;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();
        seen = 1'b0;
        lat  = -1;
        for (int j = 0; j <= 40 && !seen; j++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                lat  = j;
            end else begin
                chk1("req_ready_wait", req_ready, 1'b0);
            end
        end
        chk("latency", 32'(lat), 32'(LAT));
        if (!seen) return;
        chk("rdata", resp_rdata, v.exp_rdata);
        chk1("err", resp_err, v.exp_err);
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'($urandom);
            scramble_req();
            @(negedge clk);
            chk1("hold_valid", resp_valid, 1'b1);
            chk("hold_rdata", resp_rdata, v.exp_rdata);
            chk1("hold_err", resp_err, v.exp_err);
            chk1("hold_req_ready", req_ready, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk1("retire_valid", resp_valid, 1'b0);
        chk("retire_rdata", resp_rdata, 32'd0);
        chk1("retire_err", resp_err, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [31:0] mrd;
        logic        merr;
        int          r;
        int          idx;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 32'd0;
            known[i]   = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk1("rst_err", resp_err, 1'b0);
        reset_n = 1'b1;

        tbl.push_back(mk(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 32'h20,   32'h0,        4'hF, 0, 32'h11BB33DD, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 32'h22,   32'h0,        4'hF, 0, 32'h0,        1'b1));
        tbl.push_back(mk(1'b1, 32'h1000, 32'h5,        4'hF, 0, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 32'h0,    32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0));
        tbl.push_back(mk(1'b1, 32'h10,   32'h12345678, 4'h0, 0, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 32'h10,   32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 32'hFFC,  32'h0BADF00D, 4'hF, 2, 32'h0,        1'b0));
        tbl.push_back(mk(1'b0, 32'hFFC,  32'h0,        4'h0, 0, 32'h0BADF00D, 1'b0));
        tbl.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0,    4'h0, 1, 32'h0,        1'b1));
        tbl.push_back(mk(1'b1, 32'h3,    32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1));
        tbl.push_back(mk(1'b0, 32'h0,    32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0));

        foreach (tbl[i]) begin
            model_apply(tbl[i], mrd, merr);
            txn(tbl[i]);
        end

        // Reset mid-WAIT: the write stays committed, its response is discarded
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'h77;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_apply(mk(1'b1, 32'h8, 32'h77, 4'hF, 0, 32'h0, 1'b0), mrd, merr);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk1("midwait_rst_valid", resp_valid, 1'b0);
        chk1("midwait_rst_ready", req_ready, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk1("midwait_rst_hold_valid", resp_valid, 1'b0);
        end
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk1("post_rst_valid", resp_valid, 1'b0);
            chk1("post_rst_ready", req_ready, 1'b1);
        end
        resp_ready = 1'b0;
        txn(mk(1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h77, 1'b0));

        // Randomized traffic against the array model
        for (int n = 0; n < 150; n++) begin
            r      = $urandom_range(0, 9);
            v.we   = 1'($urandom);
            v.be   = 4'($urandom);
            v.wdata = $urandom;
            v.hold = $urandom_range(0, 3);
            if (r == 0) begin
                v.addr = $urandom;
                if (v.addr[1:0] == 2'b00) v.addr[0] = 1'b1;
            end else if (r == 1) begin
                v.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
            end else begin
                v.addr = 32'($urandom_range(0, 31) * 4);
                idx = int'(v.addr[31:2]);
                if (!known[idx]) begin
                    v.we = 1'b1;
                    v.be = 4'hF;
                end
            end
            model_apply(v, mrd, merr);
            v.exp_rdata = mrd;
            v.exp_err   = merr;
            txn(v);
        end

`ifdef DMEM_RESPONDER_STATS_EN
        reset_pulse();
        @(negedge clk);
        chk("stat_reads_rst", stat_reads, 32'd0);
        chk("stat_writes_rst", stat_writes, 32'd0);
        chk("stat_errs_rst", stat_errs, 32'd0);
        tbl.delete();
        tbl.push_back(mk(1'b1, 32'h40, 32'h1, 4'hF, 0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h44, 32'h2, 4'hF, 0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h1, 1'b0));
        tbl.push_back(mk(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h2, 1'b0));
        tbl.push_back(mk(1'b0, 32'h0,  32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0));
        tbl.push_back(mk(1'b0, 32'h41, 32'h0, 4'h0, 0, 32'h0, 1'b1));
        foreach (tbl[i]) begin
            model_apply(tbl[i], mrd, merr);
            tbl[i].exp_rdata = mrd;
            txn(tbl[i]);
        end
        chk("stat_reads", stat_reads, 32'd4);
        chk("stat_writes", stat_writes, 32'd2);
        chk("stat_errs", stat_errs, 32'd1);
`else
        reset_pulse();
        @(negedge clk);
        chk1("final_rst_ready", req_ready, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
